multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 69 ++++++
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/multicycle_ctrl_timeout_cnt.sv | 35 +++
 rtl/multicycle_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller, ImmGen and datapath:
// FSM states, base opcodes, funct3 branch codes and the datapath mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] pc_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
  } ctrl_t;

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    case (opc)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. The master side is the controller;
// the slave side is the datapath and memories that feed it status.
interface multicycle_ctrl_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       imem_ready;
  logic       dmem_ready;

  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] pc_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] wb_sel;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  opcode, funct3, alu_zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
    output pc_sel, alu_src_a, alu_src_b, alu_op, wb_sel, halted, state
  );

  modport slave (
    output opcode, funct3, alu_zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
    input  pc_sel, alu_src_a, alu_src_b, alu_op, wb_sel, halted, state
  );

endinterface

// File: rtl/multicycle_ctrl_timeout_cnt.sv
// Memory wait counter: counts cycles a request sees ready low; expired flags the
// cycle whose increment would reach LIMIT (ready in that cycle suppresses it).
module ctrl_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic rdy,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(LIMIT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !rdy)
      cnt_d = cnt_q + 4'd1;
  end

  assign expired = en && !rdy && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
// Outputs decode from state, IR fields and status; memory waits bounded by MEM_TIMEOUT.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  state_e state_q, state_d;
  logic   live_q, live_d;
  ctrl_t  ctl;
  logic   is_load, is_store, br_f3_ok, br_taken;
  logic   wait_en, wait_rdy, wait_clr, timed_out;

  assign is_load  = (bus.opcode == OP_LOAD);
  assign is_store = (bus.opcode == OP_STORE);
  assign br_f3_ok = (bus.funct3 == F3_BEQ) || (bus.funct3 == F3_BNE);
  assign br_taken = ((bus.funct3 == F3_BEQ) &&  bus.alu_zero) ||
                    ((bus.funct3 == F3_BNE) && !bus.alu_zero);

  // live_q keeps every output low until the first edge after reset release.
  assign wait_en  = live_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign wait_rdy = (state_q == ST_MEM) ? bus.dmem_ready : bus.imem_ready;
  assign wait_clr = !live_q ||
                    ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM)));

  ctrl_timeout_cnt #(.LIMIT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .en      (wait_en),
    .rdy     (wait_rdy),
    .expired (timed_out)
  );

  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    if (!live_q) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH:  if (bus.imem_ready) state_d = ST_DECODE;
                   else if (timed_out) state_d = ST_TRAP;
        ST_DECODE: state_d = is_legal_opcode(bus.opcode) ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          case (bus.opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: state_d = ST_WB;
            OP_LOAD, OP_STORE:            state_d = ST_MEM;
            OP_BRANCH:                    state_d = br_f3_ok ? ST_FETCH : ST_TRAP;
            OP_JAL, OP_JALR:              state_d = ST_FETCH;
            default:                      state_d = ST_TRAP;
          endcase
        end
        ST_MEM:    if (bus.dmem_ready) state_d = is_load ? ST_WB : ST_FETCH;
                   else if (timed_out) state_d = ST_TRAP;
        ST_WB:     state_d = ST_FETCH;
        default:   state_d = ST_TRAP;
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    if (live_q) begin
      case (state_q)
        ST_FETCH: begin
          ctl.imem_req = 1'b1;
          if (bus.imem_ready) begin
            ctl.ir_write = 1'b1;
            ctl.pc_write = 1'b1;
            ctl.pc_sel   = PC_SEL_PLUS4;
          end
        end
        ST_DECODE: begin
          ctl.alu_src_a = SRC_A_PC;
          ctl.alu_src_b = SRC_B_IMM;
          ctl.alu_op    = ALU_OP_ADD;
        end
        ST_EXEC: begin
          case (bus.opcode)
            OP_R: begin
              ctl.alu_src_a = SRC_A_RS1;
              ctl.alu_src_b = SRC_B_RS2;
              ctl.alu_op    = ALU_OP_FUNCT;
            end
            OP_I: begin
              ctl.alu_src_b = SRC_B_IMM;
              ctl.alu_op    = ALU_OP_FUNCT;
            end
            OP_LOAD, OP_STORE: begin
              ctl.alu_src_b = SRC_B_IMM;
              ctl.alu_op    = ALU_OP_ADD;
            end
            OP_BRANCH: begin
              ctl.alu_op = ALU_OP_SUB;
              if (br_taken) begin
                ctl.pc_write = 1'b1;
                ctl.pc_sel   = PC_SEL_TARGET;
              end
            end
            OP_JAL, OP_JALR: begin
              ctl.reg_write = 1'b1;
              ctl.wb_sel    = WB_SEL_PC4;
              ctl.pc_write  = 1'b1;
              ctl.pc_sel    = (bus.opcode == OP_JALR) ? PC_SEL_JALR : PC_SEL_TARGET;
              ctl.alu_src_b = (bus.opcode == OP_JALR) ? SRC_B_IMM : SRC_B_RS2;
            end
            OP_LUI: begin
              ctl.alu_src_a = SRC_A_ZERO;
              ctl.alu_src_b = SRC_B_IMM;
            end
            OP_AUIPC: begin
              ctl.alu_src_a = SRC_A_PC;
              ctl.alu_src_b = SRC_B_IMM;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          ctl.dmem_req = 1'b1;
          ctl.dmem_we  = is_store;
        end
        ST_WB: begin
          ctl.reg_write = 1'b1;
          ctl.wb_sel    = is_load ? WB_SEL_LOAD : WB_SEL_ALU;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
    end
  end

  assign bus.imem_req  = ctl.imem_req;
  assign bus.dmem_req  = ctl.dmem_req;
  assign bus.dmem_we   = ctl.dmem_we;
  assign bus.ir_write  = ctl.ir_write;
  assign bus.pc_write  = ctl.pc_write;
  assign bus.reg_write = ctl.reg_write;
  assign bus.pc_sel    = ctl.pc_sel;
  assign bus.alu_src_a = ctl.alu_src_a;
  assign bus.alu_src_b = ctl.alu_src_b;
  assign bus.alu_op    = ctl.alu_op;
  assign bus.wb_sel    = ctl.wb_sel;
  assign bus.halted    = (state_q == ST_TRAP);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle sequences built from
// the instruction class and random ready/zero stimulus, compared every cycle.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TIMEOUT = 15;

  localparam logic [6:0] T_R   = 7'b0110011, T_I    = 7'b0010011, T_LD    = 7'b0000011;
  localparam logic [6:0] T_ST  = 7'b0100011, T_BR   = 7'b1100011, T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JR  = 7'b1100111, T_LUI  = 7'b0110111, T_AUIPC = 7'b0010111;

  localparam logic [5:0] E_IMREQ = 6'b100000, E_DMREQ = 6'b010000, E_WE  = 6'b001000;
  localparam logic [5:0] E_IRW   = 6'b000100, E_PCW   = 6'b000010, E_RW  = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic need_reset = 1'b0;
  logic [6:0] cur_opc = 7'd0;
  logic [2:0] cur_f3 = 3'd0;

  logic [6:0] legal_ops [9] = '{T_R, T_I, T_LD, T_ST, T_BR, T_JAL, T_JR, T_LUI, T_AUIPC};
  logic [6:0] bad_ops [4]   = '{7'h7F, 7'h00, 7'h0F, 7'h73};

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [2:0] st, input logic [5:0] en,
                                     input logic [1:0] pcs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] wb);
    return {(st == ST_TRAP), st, en, pcs, a, b, op, wb};
  endfunction

  function automatic logic [19:0] obs();
    return {bus.halted, bus.state, bus.imem_req, bus.dmem_req, bus.dmem_we,
            bus.ir_write, bus.pc_write, bus.reg_write, bus.pc_sel,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.wb_sel};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return int'($urandom_range(0, 3));
    if (r < 16) return TIMEOUT - 1;
    if (r < 17) return TIMEOUT + 2;
    return int'($urandom_range(4, 13));
  endfunction

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic step(input string tag, input logic im_r, input logic dm_r,
                      input logic z, input logic [19:0] want);
    @(negedge clk);
    bus.imem_ready = im_r;
    bus.dmem_ready = dm_r;
    bus.alu_zero   = z;
    bus.opcode     = cur_opc;
    bus.funct3     = cur_f3;
    #1;
    chk(tag, obs(), want);
  endtask

  task automatic trap_hold();
    for (int k = 0; k < 4; k++) begin
      cur_opc = 7'($urandom_range(0, 127));
      step("trap", rb(), rb(), rb(), mk(ST_TRAP, 6'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    end
    need_reset = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_hold", obs(), mk(ST_FETCH, 6'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    @(negedge clk);
    bus.imem_ready = 1'b1;
    #1 chk("rst_hold_rdy", obs(), mk(ST_FETCH, 6'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release", obs(), mk(ST_FETCH, 6'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    need_reset = 1'b0;
  endtask

  // One instruction: fetch waits, decode, exec, optional mem waits and writeback.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                           input int fwait, input int mwait, input int abort_at);
    logic       ld, st, taken, legal;
    logic [2:0] nxt;
    logic [19:0] e;
    ld = (opc == T_LD);
    st = (opc == T_ST);
    legal = 1'b0;
    foreach (legal_ops[k]) if (legal_ops[k] == opc) legal = 1'b1;

    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == fwait) begin
        step("fetch_rdy", 1'b1, rb(), rb(),
             mk(ST_FETCH, E_IMREQ | E_IRW | E_PCW, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        break;
      end
      step("fetch_wait", 1'b0, rb(), rb(), mk(ST_FETCH, E_IMREQ, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
      if (i + 1 == TIMEOUT) begin
        trap_hold();
        return;
      end
    end
    cur_opc = opc;
    cur_f3  = f3;

    step("decode", rb(), rb(), rb(), mk(ST_DECODE, 6'b0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0));
    if (!legal) begin
      trap_hold();
      return;
    end

    taken = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z);
    nxt = ST_TRAP;
    e = '0;
    case (opc)
      T_R:     begin e = mk(ST_EXEC, 6'b0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0); nxt = ST_WB; end
      T_I:     begin e = mk(ST_EXEC, 6'b0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0); nxt = ST_WB; end
      T_LD,
      T_ST:    begin e = mk(ST_EXEC, 6'b0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0); nxt = ST_MEM; end
      T_BR: begin
        e = mk(ST_EXEC, taken ? E_PCW : 6'b0, taken ? 2'd1 : 2'd0, 2'd0, 2'd0, 2'd1, 2'd0);
        nxt = (f3 <= 3'd1) ? ST_FETCH : ST_TRAP;
      end
      T_JAL:   begin e = mk(ST_EXEC, E_RW | E_PCW, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2); nxt = ST_FETCH; end
      T_JR:    begin e = mk(ST_EXEC, E_RW | E_PCW, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2); nxt = ST_FETCH; end
      T_LUI:   begin e = mk(ST_EXEC, 6'b0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0); nxt = ST_WB; end
      T_AUIPC: begin e = mk(ST_EXEC, 6'b0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0); nxt = ST_WB; end
      default: ;
    endcase
    step("exec", rb(), rb(), z, e);
    if (nxt == ST_TRAP) begin
      trap_hold();
      return;
    end

    if (nxt == ST_MEM) begin
      e = mk(ST_MEM, E_DMREQ | (st ? E_WE : 6'b0), 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
      for (int i = 0; i < TIMEOUT; i++) begin
        if (i == mwait) begin
          step("mem_rdy", rb(), 1'b1, rb(), e);
          nxt = ld ? ST_WB : ST_FETCH;
          break;
        end
        step("mem_wait", rb(), 1'b0, rb(), e);
        if (i == abort_at) begin
          rst = 1'b1;
          #1 chk("rst_mid_mem", obs(), mk(ST_FETCH, 6'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
          need_reset = 1'b1;
          return;
        end
        if (i + 1 == TIMEOUT) begin
          trap_hold();
          return;
        end
      end
    end

    if (nxt == ST_WB)
      step("wb", rb(), rb(), rb(), mk(ST_WB, E_RW, 2'd0, 2'd0, 2'd0, 2'd0, ld ? 2'd1 : 2'd0));
  endtask

  initial begin
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    int          k;
    bus.opcode = 7'd0;
    bus.funct3 = 3'd0;
    bus.alu_zero = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;

    do_reset();
    instr = 32'h00500093;
    run_instr(instr[6:0], instr[14:12], 1'b0, 0, 0, -1);
    run_instr(T_LD, 3'd2, 1'b0, 0, 3, -1);
    run_instr(T_BR, 3'd0, 1'b1, 0, 0, -1);
    run_instr(T_BR, 3'd1, 1'b1, 1, 0, -1);
    run_instr(T_JAL, 3'd0, 1'b0, 0, 0, -1);
    run_instr(T_ST, 3'd2, 1'b0, 0, 1000, -1);
    if (need_reset) do_reset();
    run_instr(7'h7F, 3'd0, 1'b0, 0, 0, -1);
    if (need_reset) do_reset();
    run_instr(T_LD, 3'd2, 1'b0, 1, 8, 2);
    if (need_reset) do_reset();
    run_instr(T_LD, 3'd2, 1'b0, 0, TIMEOUT - 1, -1);
    run_instr(T_I, 3'd0, 1'b0, TIMEOUT - 1, 0, -1);
    run_instr(T_I, 3'd0, 1'b0, TIMEOUT, 0, -1);
    if (need_reset) do_reset();

    for (int n = 0; n < 120; n++) begin
      k = int'($urandom_range(0, 9));
      opc = (k < 9) ? legal_ops[k] : bad_ops[$urandom_range(0, 3)];
      if (opc == T_BR)
        f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
      else
        f3 = 3'($urandom_range(0, 7));
      run_instr(opc, f3, rb(), pick_wait(), pick_wait(), ($urandom_range(0, 29) == 0) ? 1 : -1);
      if (need_reset) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
